// File: rtl/pingpong_buf_ctrl_pkg.sv
// Shared bank-state encodings and default sizing for the ping-pong page buffer.
package pingpong_buf_ctrl_pkg;

    localparam int DW_DEF         = 16;
    localparam int PAGE_WORDS_DEF = 2048;
    localparam int AW_DEF         = 11;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2,
        ST_READING = 2'd3
    } bank_state_t;

endpackage

// File: rtl/pingpong_buf_ctrl_bank_slot.sv
// One bank's life cycle: EMPTY -> FILLING -> FULL -> READING -> EMPTY.
//
//  state      | meaning
//  -----------+-------------------------------------------------
//  ST_EMPTY   | no valid words, writer may start a page here
//  ST_FILLING | writer has put at least one word in this bank
//  ST_FULL    | page closed, len valid, offered to the reader
//  ST_READING | reader holds the bank, writes are dropped
module pp_bank_slot
    import pingpong_buf_ctrl_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        open,
    input  logic        close,
    input  logic [AW:0] close_len,
    input  logic        ack,
    input  logic        done,
    output bank_state_t state,
    output logic [AW:0] len
);

    bank_state_t state_nxt;
    logic [AW:0] len_nxt;

    // State and length registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
            len   <= '0;
        end else begin
            state <= state_nxt;
            len   <= len_nxt;
        end
    end

    // Next state; a close wins over an open in the same cycle (the last word of a page).
    always_comb begin
        state_nxt = state;
        len_nxt   = len;
        unique case (state)
            ST_EMPTY, ST_FILLING: begin
                if (close) begin
                    state_nxt = ST_FULL;
                    len_nxt   = close_len;
                end else if (open) begin
                    state_nxt = ST_FILLING;
                end
            end
            ST_FULL: begin
                if (ack) state_nxt = ST_READING;
            end
            ST_READING: begin
                if (done) state_nxt = ST_EMPTY;
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

endmodule

// File: rtl/pingpong_buf_ctrl.sv
// Ping-pong page buffer sequencer: write pointer, bank pointers, drop accounting.
module pingpong_buf_ctrl
    import pingpong_buf_ctrl_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int PAGE_WORDS = PAGE_WORDS_DEF,
    parameter int AW         = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          flush,
    input  logic          page_ack,
    input  logic          page_done,
    input  logic          ovf_clr,
    output logic          ram_we,
    output logic [AW:0]   ram_waddr,
    output logic [DW-1:0] ram_wdata,
    output logic          page_rdy,
    output logic          rd_bank,
    output logic [AW:0]   rd_len,
    output logic          wr_bank,
    output logic          overflow,
    output logic [15:0]   drop_cnt
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(PAGE_WORDS - 1);

    logic [AW-1:0] wr_addr;
    bank_state_t   st  [2];
    logic [AW:0]   len [2];

    logic        wr_ok;
    logic        accept;
    logic        drop;
    logic        close;
    logic [AW:0] close_len;
    logic        rd_ack;
    logic        rd_done;

    // Acceptance and page-close decisions, all from registered state.
    always_comb begin
        wr_ok     = (st[wr_bank] == ST_EMPTY) || (st[wr_bank] == ST_FILLING);
        accept    = wr_en && wr_ok;
        drop      = wr_en && !wr_ok;
        close_len = accept ? ({1'b0, wr_addr} + 1'b1) : {1'b0, wr_addr};
        // A flush closes whatever is in the page including a word accepted this cycle.
        close     = (accept && (wr_addr == LAST_ADDR)) ||
                    (flush && (accept || (st[wr_bank] == ST_FILLING)) && (close_len != '0));
        page_rdy  = (st[rd_bank] == ST_FULL);
        rd_ack    = page_ack && page_rdy;
        rd_done   = page_done && (st[rd_bank] == ST_READING);
        rd_len    = len[rd_bank];
    end

    for (genvar i = 0; i < 2; i++) begin : g_slot
        pp_bank_slot #(.AW(AW)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .open      (accept && (wr_bank == 1'(i))),
            .close     (close && (wr_bank == 1'(i))),
            .close_len (close_len),
            .ack       (rd_ack && (rd_bank == 1'(i))),
            .done      (rd_done && (rd_bank == 1'(i))),
            .state     (st[i]),
            .len       (len[i])
        );
    end

    // Write pointer, bank pointers and the registered RAM write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr   <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            ram_we    <= 1'b0;
            ram_waddr <= '0;
            ram_wdata <= '0;
        end else begin
            ram_we <= accept;
            if (accept) begin
                ram_waddr <= {wr_bank, wr_addr};
                ram_wdata <= wr_data;
            end
            if (close) begin
                wr_addr <= '0;
                wr_bank <= ~wr_bank;
            end else if (accept) begin
                wr_addr <= wr_addr + 1'b1;
            end
            if (rd_done) rd_bank <= ~rd_bank;
        end
    end

    // Sticky overflow and saturating drop counter; clear beats a simultaneous drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
module tb_pingpong_buf_ctrl;

    localparam int PW = 2048;
    localparam int B_EMPTY = 0, B_FILL = 1, B_FULL = 2, B_READ = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic        flush = 1'b0;
    logic        page_ack = 1'b0;
    logic        page_done = 1'b0;
    logic        ovf_clr = 1'b0;
    logic        ram_we;
    logic [11:0] ram_waddr;
    logic [15:0] ram_wdata;
    logic        page_rdy;
    logic        rd_bank;
    logic [11:0] rd_len;
    logic        wr_bank;
    logic        overflow;
    logic [15:0] drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // behavioural model: per-bank fill status, word counts, pointers
    int m_st [2];
    int m_len [2];
    int m_wb, m_wa, m_rb, m_ovf, m_cnt, m_we, m_waddr, m_wdata;

    pingpong_buf_ctrl dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
        .page_ack(page_ack), .page_done(page_done), .ovf_clr(ovf_clr),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .page_rdy(page_rdy), .rd_bank(rd_bank), .rd_len(rd_len), .wr_bank(wr_bank),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st[0] = B_EMPTY; m_st[1] = B_EMPTY; m_len[0] = 0; m_len[1] = 0;
        m_wb = 0; m_wa = 0; m_rb = 0; m_ovf = 0; m_cnt = 0;
        m_we = 0; m_waddr = 0; m_wdata = 0;
    endtask

    task automatic model_step(input bit w, input int d, input bit f, input bit a, input bit dn, input bit c);
        int pre [2];
        int words;
        bit acc;
        pre[0] = m_st[0]; pre[1] = m_st[1];
        acc = w && (pre[m_wb] == B_EMPTY || pre[m_wb] == B_FILL);
        m_we = acc ? 1 : 0;
        if (acc) begin
            m_waddr = m_wb * PW + m_wa;
            m_wdata = d;
        end
        words = m_wa + (acc ? 1 : 0);
        if ((acc && words == PW) || (f && (acc || pre[m_wb] == B_FILL) && words > 0)) begin
            m_st[m_wb] = B_FULL; m_len[m_wb] = words; m_wa = 0; m_wb = 1 - m_wb;
        end else if (acc) begin
            m_st[m_wb] = B_FILL; m_wa = words;
        end
        if (a && pre[m_rb] == B_FULL) m_st[m_rb] = B_READ;
        if (dn && pre[m_rb] == B_READ) begin
            m_st[m_rb] = B_EMPTY; m_rb = 1 - m_rb;
        end
        if (c) begin
            m_ovf = 0; m_cnt = 0;
        end else if (w && !acc) begin
            m_ovf = 1;
            if (m_cnt < 65535) m_cnt++;
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".ram_we"}, 32'(ram_we), 32'(m_we));
        chk({tag, ".ram_waddr"}, 32'(ram_waddr), 32'(m_waddr));
        chk({tag, ".ram_wdata"}, 32'(ram_wdata), 32'(m_wdata));
        chk({tag, ".page_rdy"}, 32'(page_rdy), 32'(m_st[m_rb] == B_FULL));
        chk({tag, ".rd_bank"}, 32'(rd_bank), 32'(m_rb));
        chk({tag, ".rd_len"}, 32'(rd_len), 32'(m_len[m_rb]));
        chk({tag, ".wr_bank"}, 32'(wr_bank), 32'(m_wb));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_cnt));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".ram_we"}, 32'(ram_we), 0);
        chk({tag, ".ram_waddr"}, 32'(ram_waddr), 0);
        chk({tag, ".ram_wdata"}, 32'(ram_wdata), 0);
        chk({tag, ".page_rdy"}, 32'(page_rdy), 0);
        chk({tag, ".rd_bank"}, 32'(rd_bank), 0);
        chk({tag, ".rd_len"}, 32'(rd_len), 0);
        chk({tag, ".wr_bank"}, 32'(wr_bank), 0);
        chk({tag, ".overflow"}, 32'(overflow), 0);
        chk({tag, ".drop_cnt"}, 32'(drop_cnt), 0);
    endtask

    // one clock: drive, advance, update model, compare everything
    task automatic cyc(input bit w, input int d, input bit f, input bit a, input bit dn, input bit c);
        wr_en = w; wr_data = 16'(d); flush = f; page_ack = a; page_done = dn; ovf_clr = c;
        @(posedge clk);
        model_step(w, d, f, a, dn, c);
        #1;
        chk_model("cyc");
        wr_en = 0; flush = 0; page_ack = 0; page_done = 0; ovf_clr = 0;
    endtask

    task automatic apply_reset();
        wr_en = 0; flush = 0; page_ack = 0; page_done = 0; ovf_clr = 0;
        rst_n = 0;
        #13;
        model_reset();
        @(negedge clk);
        rst_n = 1;
        #1;
        chk_zero("reset");
    endtask

    task automatic write_n(input int n);
        for (int i = 0; i < n; i++) cyc(1, $urandom_range(0, 65535), 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        apply_reset();

        // 1: one full page back to back
        for (int i = 0; i < PW; i++) begin
            cyc(1, $urandom_range(0, 65535), 0, 0, 0, 0);
            if (i == 0 || i == PW - 1) chk("t1.addr", 32'(ram_waddr), 32'(i));
        end
        chk("t1.page_rdy", 32'(page_rdy), 1);
        chk("t1.rd_bank", 32'(rd_bank), 0);
        chk("t1.rd_len", 32'(rd_len), 2048);
        chk("t1.wr_bank", 32'(wr_bank), 1);

        // 2: both banks full, then drops and clear
        write_n(PW);
        for (int i = 0; i < 5; i++) begin
            cyc(1, i, 0, 0, 0, 0);
            chk("t2.we", 32'(ram_we), 0);
        end
        chk("t2.overflow", 32'(overflow), 1);
        chk("t2.drop_cnt", 32'(drop_cnt), 5);
        cyc(0, 0, 0, 0, 0, 1);
        chk("t2.ovf_clr", 32'(overflow), 0);
        chk("t2.cnt_clr", 32'(drop_cnt), 0);
        cyc(1, 7, 0, 0, 0, 1);
        chk("t2.clr_prio", 32'(drop_cnt), 0);

        // 3: partial page flush, flush at empty pointer is a no-op
        apply_reset();
        write_n(100);
        cyc(0, 0, 1, 0, 0, 0);
        chk("t3.rd_len", 32'(rd_len), 100);
        chk("t3.page_rdy", 32'(page_rdy), 1);
        chk("t3.wr_bank", 32'(wr_bank), 1);
        cyc(0, 0, 1, 0, 0, 0);
        chk("t3.noop_wb", 32'(wr_bank), 1);
        chk("t3.noop_len", 32'(rd_len), 100);
        cyc(1, 16'h1234, 0, 0, 0, 0);
        chk("t3.next_addr", 32'(ram_waddr), 32'h800);
        // flush together with a word: page length includes it
        write_n(8);
        cyc(1, 16'hBEEF, 1, 0, 0, 0);
        chk("t3.wf_wb", 32'(wr_bank), 0);

        // 4: free bank 0 with a same-cycle write
        apply_reset();
        write_n(2 * PW);
        cyc(0, 0, 0, 1, 0, 0);
        chk("t4.ack_rdy", 32'(page_rdy), 0);
        cyc(1, 16'hAAAA, 0, 0, 1, 0);
        chk("t4.drop_we", 32'(ram_we), 0);
        chk("t4.drop_cnt", 32'(drop_cnt), 1);
        chk("t4.rd_bank", 32'(rd_bank), 1);
        cyc(1, 16'h5555, 0, 0, 0, 0);
        chk("t4.we", 32'(ram_we), 1);
        chk("t4.addr", 32'(ram_waddr), 0);
        chk("t4.data", 32'(ram_wdata), 32'h5555);

        // 5: stray page_done / page_ack
        apply_reset();
        cyc(0, 0, 0, 0, 1, 0);
        chk_zero("t5.done");
        cyc(0, 0, 0, 1, 0, 0);
        chk_zero("t5.ack");

        // 6: async reset mid-fill
        write_n(37);
        #2;
        rst_n = 0;
        #1;
        chk_zero("t6.async");
        model_reset();
        @(negedge clk);
        rst_n = 1;
        cyc(1, 16'h0042, 0, 0, 0, 0);
        chk("t6.restart_addr", 32'(ram_waddr), 0);

        // random traffic against the model
        apply_reset();
        for (int i = 0; i < 6000; i++) begin
            cyc($urandom_range(0, 9) < 8, $urandom_range(0, 65535),
                $urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 299) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
